// File: rtl/dmem_arbiter.sv
// Shares one byte-enabled data memory port between the CPU MEM stage and a DMA/debug
// requester. CPU wins by default; a starvation counter forces a bounded DMA window.
//
// state   | meaning
// ARB_CPU | CPU has priority; DMA is served only when the CPU is idle
// ARB_DMA | forced DMA window; the CPU is stalled while DMA keeps requesting
module dmem_arbiter #(
   parameter int MAX_WAIT  = 4,
   parameter int DMA_BURST = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cpu_req,
   input  logic        i_cpu_we,
   input  logic [3:0]  i_cpu_be,
   input  logic [31:0] i_cpu_addr,
   input  logic [31:0] i_cpu_wd,
   output logic [31:0] o_cpu_rd,
   output logic        o_cpu_stall,
   input  logic        i_dma_req,
   input  logic        i_dma_we,
   input  logic [3:0]  i_dma_be,
   input  logic [31:0] i_dma_addr,
   input  logic [31:0] i_dma_wd,
   output logic        o_dma_gnt,
   output logic [31:0] o_dma_rdata,
   output logic        o_dma_rvalid,
   output logic        o_mem_we,
   output logic [3:0]  o_mem_be,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wd,
   input  logic [31:0] i_mem_rd
);

   localparam int SW = $clog2(MAX_WAIT + 1);
   localparam int BW = (DMA_BURST > 1) ? $clog2(DMA_BURST) : 1;
   localparam logic [SW-1:0] LP_WAIT_LAST  = SW'(MAX_WAIT - 1);
   localparam logic [BW-1:0] LP_BURST_LAST = BW'(DMA_BURST - 1);

   typedef enum logic {ARB_CPU, ARB_DMA} arb_state_t;

   arb_state_t    r_state;
   logic [SW-1:0] r_starve_cnt;
   logic [BW-1:0] r_burst_cnt;
   logic [31:0]   r_dma_rdata;
   logic          r_dma_rvalid;
   logic          w_gnt_dma;
   logic          w_gnt_cpu;

   // Grants are forced low while reset is held so nothing reaches memory mid-reset.
   always_comb begin
      w_gnt_dma = 1'b0;
      if (!i_reset) begin
         if (r_state == ARB_DMA) w_gnt_dma = i_dma_req;
         else                    w_gnt_dma = i_dma_req & ~i_cpu_req;
      end
   end

   assign w_gnt_cpu = i_cpu_req & ~w_gnt_dma & ~i_reset;

   always_comb begin
      o_mem_we   = 1'b0;
      o_mem_be   = 4'h0;
      o_mem_addr = i_cpu_addr;
      o_mem_wd   = i_cpu_wd;
      if (w_gnt_dma) begin
         o_mem_we   = i_dma_we;
         o_mem_be   = i_dma_be;
         o_mem_addr = i_dma_addr;
         o_mem_wd   = i_dma_wd;
      end else if (w_gnt_cpu) begin
         o_mem_we   = i_cpu_we;
         o_mem_be   = i_cpu_be;
      end
   end

   assign o_cpu_rd     = i_mem_rd;
   assign o_cpu_stall  = i_cpu_req & w_gnt_dma;
   assign o_dma_gnt    = w_gnt_dma;
   assign o_dma_rdata  = r_dma_rdata;
   assign o_dma_rvalid = r_dma_rvalid;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ARB_CPU;
         r_starve_cnt <= '0;
         r_burst_cnt  <= '0;
         r_dma_rdata  <= 32'h0;
         r_dma_rvalid <= 1'b0;
      end else begin
         r_dma_rvalid <= w_gnt_dma & ~i_dma_we;
         if (w_gnt_dma && !i_dma_we) r_dma_rdata <= i_mem_rd;
         case (r_state)
            ARB_CPU: begin
               if (i_cpu_req && i_dma_req) begin
                  if (r_starve_cnt == LP_WAIT_LAST) begin
                     r_state      <= ARB_DMA;
                     r_starve_cnt <= '0;
                  end else begin
                     r_starve_cnt <= r_starve_cnt + 1'b1;
                  end
               end else begin
                  r_starve_cnt <= '0;
               end
            end
            ARB_DMA: begin
               // Exit decision uses the burst count before this beat is added.
               if (!i_dma_req || (w_gnt_dma && r_burst_cnt == LP_BURST_LAST)) begin
                  r_state     <= ARB_CPU;
                  r_burst_cnt <= '0;
               end else if (w_gnt_dma) begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
               end
            end
            default: r_state <= ARB_CPU;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a window/denial-count model and a reference memory.
module tb_dmem_arbiter;

   localparam int MAX_WAIT  = 4;
   localparam int DMA_BURST = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [3:0]  cpu_be, dma_be;
   logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd;
   logic [31:0] cpu_rd, dma_rdata, mem_addr, mem_wd, mem_rd;
   logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;
   logic [3:0]  mem_be;
   logic        mem_init;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .DMA_BURST(DMA_BURST)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_be(cpu_be),
      .i_cpu_addr(cpu_addr), .i_cpu_wd(cpu_wd), .o_cpu_rd(cpu_rd), .o_cpu_stall(cpu_stall),
      .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_be(dma_be),
      .i_dma_addr(dma_addr), .i_dma_wd(dma_wd), .o_dma_gnt(dma_gnt),
      .o_dma_rdata(dma_rdata), .o_dma_rvalid(dma_rvalid),
      .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr), .o_mem_wd(mem_wd),
      .i_mem_rd(mem_rd)
   );

   assign mem_rd = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[8] <= 32'h12345678;
      end else if (mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_wd[b*8 +: 8];
      end
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc_start();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req = 0; cpu_we = 0; cpu_be = 4'h0; cpu_addr = 32'h0; cpu_wd = 32'h0;
      dma_req = 0; dma_we = 0; dma_be = 4'h0; dma_addr = 32'h0; dma_wd = 32'h0;
   endtask

   // Both sides request continuously; pat[i] = expected DMA grant in cycle i.
   task automatic both_seq(input int n, input logic [31:0] pat);
      for (int i = 0; i < n; i++) begin
         cyc_start();
         cpu_req = 1; cpu_we = 0; cpu_be = 4'hF; cpu_addr = 32'h40;
         dma_req = 1; dma_we = 0; dma_be = 4'hF; dma_addr = 32'h44;
         @(negedge clk);
         chk($sformatf("seq_gnt[%0d]", i), 32'(dma_gnt), 32'(pat[i]));
         chk($sformatf("seq_stall[%0d]", i), 32'(cpu_stall), 32'(pat[i]));
         chk($sformatf("seq_addr[%0d]", i), mem_addr, pat[i] ? 32'h44 : 32'h40);
      end
   endtask

   typedef struct {
      logic        c_req, c_we; logic [3:0] c_be; logic [31:0] c_addr, c_wd;
      logic        d_req, d_we; logic [3:0] d_be; logic [31:0] d_addr, d_wd;
      logic        e_we, e_gnt, e_stall; logic [3:0] e_be; logic [31:0] e_addr;
      logic        e_rv; logic [31:0] e_rdata;
   } vec_t;

   vec_t tbl[9];

   int          win, denied, streak, max_streak;
   logic        g_dma, g_cpu, e_we, prev_rv;
   logic [31:0] prev_rdata, ga;
   logic        cpu_hold, dma_hold;

   initial begin
      tbl[0] = '{1,1,4'hF,32'h10,32'hDEADBEEF, 0,0,4'h0,32'h0,32'h0,   1,0,0,4'hF,32'h10, 0,32'h0};
      tbl[1] = '{0,0,4'h0,32'h0,32'h0, 1,0,4'hF,32'h20,32'h0,         0,1,0,4'hF,32'h20, 1,32'h12345678};
      tbl[2] = '{0,1,4'hF,32'h44,32'h1111, 0,1,4'hF,32'h48,32'h2222,  0,0,0,4'h0,32'h44, 0,32'h0};
      tbl[3] = '{1,0,4'hF,32'h30,32'h0, 1,1,4'hF,32'h34,32'h77,       0,0,0,4'hF,32'h30, 0,32'h0};
      tbl[4] = '{1,1,4'hC,32'h38,32'hA5A5A5A5, 1,1,4'hF,32'h3C,32'h9, 1,0,0,4'hC,32'h38, 0,32'h0};
      tbl[5] = '{0,0,4'h0,32'h0,32'h0, 1,1,4'h3,32'h28,32'hCAFEBEEF,  1,1,0,4'h3,32'h28, 0,32'h0};
      tbl[6] = '{1,0,4'h1,32'h10,32'h0, 0,0,4'h0,32'h0,32'h0,         0,0,0,4'h1,32'h10, 0,32'h0};
      tbl[7] = '{0,0,4'h0,32'h0,32'h0, 1,0,4'hF,32'h10,32'h0,         0,1,0,4'hF,32'h10, 1,32'hDEADBEEF};
      tbl[8] = '{0,0,4'h0,32'h0,32'h0, 1,0,4'hF,32'h28,32'h0,         0,1,0,4'hF,32'h28, 1,32'h0000BEEF};

      idle();
      dma_req = 1; dma_addr = 32'h20; dma_be = 4'hF;
      rst = 1; mem_init = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(dma_gnt), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_rvalid", 32'(dma_rvalid), 0);
      chk("rst_rdata", dma_rdata, 0);
      cyc_start();
      rst = 0; mem_init = 0; idle();

      foreach (tbl[k]) begin
         cyc_start();
         cpu_req = tbl[k].c_req; cpu_we = tbl[k].c_we; cpu_be = tbl[k].c_be;
         cpu_addr = tbl[k].c_addr; cpu_wd = tbl[k].c_wd;
         dma_req = tbl[k].d_req; dma_we = tbl[k].d_we; dma_be = tbl[k].d_be;
         dma_addr = tbl[k].d_addr; dma_wd = tbl[k].d_wd;
         @(negedge clk);
         chk($sformatf("v%0d_we", k), 32'(mem_we), 32'(tbl[k].e_we));
         chk($sformatf("v%0d_gnt", k), 32'(dma_gnt), 32'(tbl[k].e_gnt));
         chk($sformatf("v%0d_stall", k), 32'(cpu_stall), 32'(tbl[k].e_stall));
         chk($sformatf("v%0d_be", k), 32'(mem_be), 32'(tbl[k].e_be));
         chk($sformatf("v%0d_addr", k), mem_addr, tbl[k].e_addr);
         cyc_start();
         idle();
         @(negedge clk);
         chk($sformatf("v%0d_rvalid", k), 32'(dma_rvalid), 32'(tbl[k].e_rv));
         if (tbl[k].e_rv) chk($sformatf("v%0d_rdata", k), dma_rdata, tbl[k].e_rdata);
      end

      // Starvation window: 4 denied cycles, 2 DMA beats, then the pattern repeats.
      both_seq(12, 32'hC30);
      cyc_start(); idle();

      // DMA drops its request after one forced beat.
      both_seq(5, 32'h10);
      cyc_start();
      idle(); cpu_req = 1; cpu_be = 4'hF; cpu_addr = 32'h40;
      @(negedge clk);
      chk("drop_gnt", 32'(dma_gnt), 0);
      chk("drop_stall", 32'(cpu_stall), 0);
      chk("drop_addr", mem_addr, 32'h40);
      both_seq(6, 32'h30);
      cyc_start(); idle();

      // Reset lands on a forced-window DMA read beat.
      both_seq(4, 32'h0);
      cyc_start();
      cpu_req = 1; cpu_be = 4'hF; cpu_addr = 32'h40;
      dma_req = 1; dma_we = 0; dma_be = 4'hF; dma_addr = 32'h44;
      #1 rst = 1;
      @(negedge clk);
      chk("rstmid_gnt", 32'(dma_gnt), 0);
      chk("rstmid_we", 32'(mem_we), 0);
      chk("rstmid_stall", 32'(cpu_stall), 0);
      cyc_start();
      rst = 0; idle();
      @(negedge clk);
      chk("rstmid_rvalid", 32'(dma_rvalid), 0);
      both_seq(6, 32'h30);

      // Randomized traffic against the reference model.
      cyc_start(); idle(); rst = 1;
      cyc_start(); rst = 0;
      for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
      win = 0; denied = 0; streak = 0; max_streak = 0;
      prev_rv = 0; prev_rdata = 0; cpu_hold = 0; dma_hold = 0;
      for (int c = 0; c < 10000; c++) begin
         cyc_start();
         if (!cpu_hold) begin
            cpu_req = ($urandom_range(0, 99) < 60);
            cpu_we = 1'($urandom_range(0, 1)); cpu_be = 4'($urandom_range(1, 15));
            cpu_addr = 32'($urandom_range(0, 63)) << 2; cpu_wd = $urandom;
         end
         if (!dma_hold) begin
            dma_req = ($urandom_range(0, 99) < 45);
            dma_we = 1'($urandom_range(0, 1)); dma_be = 4'($urandom_range(1, 15));
            dma_addr = 32'($urandom_range(0, 63)) << 2; dma_wd = $urandom;
         end
         g_dma = (win > 0) ? dma_req : (dma_req & ~cpu_req);
         g_cpu = cpu_req & ~g_dma;
         e_we  = g_dma ? dma_we : (g_cpu & cpu_we);
         @(negedge clk);
         chk("rnd_gnt", 32'(dma_gnt), 32'(g_dma));
         chk("rnd_stall", 32'(cpu_stall), 32'(cpu_req & g_dma));
         chk("rnd_we", 32'(mem_we), 32'(e_we));
         if (g_dma) chk("rnd_dma_addr", mem_addr, dma_addr);
         if (g_cpu) chk("rnd_cpu_addr", mem_addr, cpu_addr);
         if (g_cpu && !cpu_we) chk("rnd_cpu_rd", cpu_rd, ref_mem[cpu_addr[7:2]]);
         chk("rnd_rvalid", 32'(dma_rvalid), 32'(prev_rv));
         if (prev_rv) chk("rnd_rdata", dma_rdata, prev_rdata);

         prev_rv = g_dma & ~dma_we;
         if (prev_rv) prev_rdata = ref_mem[dma_addr[7:2]];
         if (e_we) begin
            ga = g_dma ? dma_addr : cpu_addr;
            ref_mem[ga[7:2]] = merge(ref_mem[ga[7:2]], g_dma ? dma_wd : cpu_wd,
                                     g_dma ? dma_be : cpu_be);
         end
         if (dma_req && !g_dma) begin
            streak++;
            if (streak > max_streak) max_streak = streak;
         end else begin
            streak = 0;
         end
         if (win > 0) begin
            if (!dma_req || win == 1) win = 0;
            else win--;
         end else if (cpu_req && dma_req) begin
            denied++;
            if (denied == MAX_WAIT) begin
               win = DMA_BURST;
               denied = 0;
            end
         end else begin
            denied = 0;
         end
         cpu_hold = cpu_req & g_dma;
         dma_hold = dma_req & ~g_dma;
      end
      cyc_start(); idle();
      @(negedge clk);
      chk("rnd_starve_bound", 32'(max_streak <= MAX_WAIT), 1);
      for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
